// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the funct3 size codes, the FSM state encoding and the byte-enable masks.
// Small helpers decode a size code into its byte count and validity.
package dmem_ctrl_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC0    = 3'd1,
    ACC1    = 3'd2,
    WAIT_LD = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic size_ok(input logic [2:0] sz);
    return (sz inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
  endfunction

  function automatic logic [3:0] base_mask(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: return MASK_B;
      SZ_H, SZ_HU: return MASK_H;
      default:     return MASK_W;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: return 3'd1;
      SZ_H, SZ_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: shifts a two-word window right by the byte offset and extends.
// Latency: purely combinational.
// Backpressure: none, result follows inputs.
module dmem_load_align
  import dmem_ctrl_pkg::*;
(
  input  logic [63:0] i_window,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  output logic [31:0] o_rdata
);

  logic [31:0] w_win;

  assign w_win = 32'(i_window >> {i_off, 3'b000});

  // Sign- or zero-extend the selected lanes according to the size code.
  always_comb begin
    o_rdata = w_win;
    case (i_size)
      SZ_B:    o_rdata = {{24{w_win[7]}}, w_win[7:0]};
      SZ_BU:   o_rdata = {24'd0, w_win[7:0]};
      SZ_H:    o_rdata = {{16{w_win[15]}}, w_win[15:0]};
      SZ_HU:   o_rdata = {16'd0, w_win[15:0]};
      default: o_rdata = w_win;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// LSU-to-RAM access controller: splits misaligned accesses into two word accesses.
// Latency: aligned ld 3, aligned st 2, split ld 4, split st 3, rejected 1 cycle.
// Backpressure: req_ready only in IDLE; resp_valid is a single unstalled pulse.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_t      r_state, w_next;
  logic        r_we, r_split, r_err;
  logic [2:0]  r_size;
  logic [1:0]  r_off;
  logic [29:0] r_a;
  logic [31:0] r_wdata, r_lo, r_hi;

  logic        w_accept, w_split_in, w_err_in;
  logic [1:0]  w_off;
  logic [29:0] w_a;
  logic [63:0] w_wdata64;
  logic [7:0]  w_mask8;
  logic [31:0] w_load_data;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_off      = req_addr[1:0];
  assign w_a        = req_addr[31:2];
  assign w_split_in = ({2'b00, w_off} + {1'b0, size_bytes(req_size)}) > 4'd4;
  // A split access whose second word falls off the end is rejected whole, so
  // the first half is never written.
  assign w_err_in   = !size_ok(req_size)
                   || ({2'b00, w_a} >= DEPTH)
                   || (w_split_in && (({2'b00, w_a} + 32'd1) >= DEPTH));

  assign w_wdata64  = {32'd0, r_wdata} << {r_off, 3'b000};
  assign w_mask8    = {4'd0, base_mask(r_size)} << r_off;

  dmem_load_align u_load_align (
    .i_window (
      {r_hi, r_lo}),
    .i_off    (r_off),
    .i_size   (r_size),
    .o_rdata  (w_load_data)
  );

  // State register and request/read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_a     <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_off   <= w_off;
        r_a     <= w_a;
        r_split <= w_split_in;
        r_err   <= w_err_in;
        r_wdata <= req_wdata;
        r_lo    <= '0;
        r_hi    <= '0;
      end else if (r_state == ACC1 && !r_we) begin
        r_lo <= mem_rdata;
      end else if (r_state == WAIT_LD) begin
        if (r_split) r_hi <= mem_rdata;
        else         r_lo <= mem_rdata;
      end
    end
  end

  // Next-state decode and per-state drive of the request, response and RAM ports.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_wmask  = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_err_in ? DONE : ACC0;
      end
      ACC0: begin
        mem_en   = 1'b1;
        mem_addr = {2'b00, r_a};
        if (r_we) begin
          mem_wmask = w_mask8[3:0];
          mem_wdata = w_wdata64[31:0];
        end
        w_next = r_split ? ACC1 : (r_we ? DONE : WAIT_LD);
      end
      ACC1: begin
        mem_en   = 1'b1;
        mem_addr = {2'b00, r_a} + 32'd1;
        if (r_we) begin
          mem_wmask = w_mask8[7:4];
          mem_wdata = w_wdata64[63:32];
        end
        w_next = r_we ? DONE : WAIT_LD;
      end
      WAIT_LD: w_next = DONE;
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_we) resp_rdata = w_load_data;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-level reference model predicts every output cycle.
// Directed cases pin the model with hand-computed values; random requests follow.
// An attached word RAM answers reads one cycle after the strobe.
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  dmem_access_ctrl #(.MEM_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        en;
    logic [3:0]  wm;
    logic [31:0] ad;
    logic [31:0] wd;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          run = 1'b0;
  vec_t        exp_q[$];
  logic [31:0] ram [D];
  logic [7:0]  sh [4*D];

  function automatic vec_t mkv(logic rdy, logic rv, logic [31:0] rd, logic err,
                               logic en, logic [3:0] wm, logic [31:0] ad, logic [31:0] wd);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.err = err;
    v.en = en; v.wm = wm; v.ad = ad; v.wd = wd;
    return v;
  endfunction

  function automatic int nbytes(logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference: predict the whole per-cycle output trace of one accepted request.
  function automatic void model_accept();
    int          n, off;
    logic [63:0] a0, first, last, d64;
    logic [7:0]  m8;
    logic [31:0] val;
    bit          bad, split;
    n   = nbytes(req_size);
    a0  = {32'd0, req_addr};
    off = int'(a0 % 4);
    first = a0 >> 2;
    last  = (a0 + 64'(n == 0 ? 1 : n) - 64'd1) >> 2;
    bad   = (n == 0) || (first >= 64'(D)) || (last >= 64'(D));
    split = (last != first);
    if (bad) begin
      exp_q.push_back(mkv(0, 1, 0, 1, 0, 0, 0, 0));
    end else if (req_we) begin
      d64 = {32'd0, req_wdata} << (8 * off);
      m8  = 8'(((1 << n) - 1) << off);
      exp_q.push_back(mkv(0, 0, 0, 0, 1, m8[3:0], first[31:0], d64[31:0]));
      if (split) exp_q.push_back(mkv(0, 0, 0, 0, 1, m8[7:4], first[31:0] + 1, d64[63:32]));
      for (int i = 0; i < n; i++) sh[int'(a0) + i] = req_wdata[8*i +: 8];
      exp_q.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0));
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = sh[int'(a0) + i];
      if ((req_size == 3'b000 || req_size == 3'b001) && val[8*n-1])
        val = val | (32'hFFFF_FFFF << (8 * n));
      exp_q.push_back(mkv(0, 0, 0, 0, 1, 0, first[31:0], 0));
      if (split) exp_q.push_back(mkv(0, 0, 0, 0, 1, 0, first[31:0] + 1, 0));
      exp_q.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mkv(0, 1, val, 0, 0, 0, 0, 0));
    end
  endfunction

  // Model sequencing: consume one expected cycle per edge, accept only when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (req_valid) model_accept();
  end

  // Every-cycle comparison of all DUT outputs against the predicted trace.
  always @(negedge clk) begin
    vec_t e, a;
    if (run) begin
      e = (exp_q.size() != 0) ? exp_q[0] : mkv(1, 0, 0, 0, 0, 0, 0, 0);
      a = mkv(req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_wmask, mem_addr, mem_wdata);
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle t=%0t got rdy=%b rv=%b rd=%h err=%b en=%b wm=%b ad=%h wd=%h exp rdy=%b rv=%b rd=%h err=%b en=%b wm=%b ad=%h wd=%h",
                 $time, a.rdy, a.rv, a.rd, a.err, a.en, a.wm, a.ad, a.wd,
                 e.rdy, e.rv, e.rd, e.err, e.en, e.wm, e.ad, e.wd);
      end
    end
  end

  // RAM model: sample the strobe mid-cycle, act on the following edge.
  logic        c_en = 1'b0;
  logic [3:0]  c_wm = '0;
  logic [31:0] c_ad = '0, c_wd = '0;
  always @(negedge clk) begin
    c_en = mem_en; c_wm = mem_wmask; c_ad = mem_addr; c_wd = mem_wdata;
  end
  always @(posedge clk) begin
    if (c_en && c_ad < 32'(D)) begin
      if (c_wm == 4'b0000) mem_rdata <= ram[c_ad];
      else for (int k = 0; k < 4; k++) if (c_wm[k]) ram[c_ad][8*k +: 8] = c_wd[8*k +: 8];
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    ram[idx] = v;
    for (int k = 0; k < 4; k++) sh[4*idx + k] = v[8*k +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int          cap_n;
  logic [31:0] cap_ad [2];
  logic [3:0]  cap_wm [2];
  logic [31:0] cap_wd [2];

  task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er);
    lat = 0; rd = '0; er = 1'b0; cap_n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en && cap_n < 2) begin
        cap_ad[cap_n] = mem_addr; cap_wm[cap_n] = mem_wmask; cap_wd[cap_n] = mem_wdata;
        cap_n++;
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no resp_valid within 20 cycles for addr %h", addr);
    end
  endtask

  int          lat, rdy_cnt, rsp_cnt;
  logic [31:0] rd, saved9;
  logic        er;
  logic [7:0]  saved_sh [4];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < D; i++) preload(i, $urandom());
    run = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    preload(5, 32'h8899AABB);
    do_req(1'b0, SZ_B, 32'h15, 32'h0, lat, rd, er);
    chk("lb rdata", rd, 32'hFFFFFFAA);
    chk("lb latency", 32'(lat), 32'd3);
    chk("lb err", 32'(er), 32'd0);

    do_req(1'b1, SZ_W, 32'h0E, 32'h11223344, lat, rd, er);
    chk("sw latency", 32'(lat), 32'd3);
    chk("sw strobes", 32'(cap_n), 32'd2);
    chk("sw acc0 addr", cap_ad[0], 32'd3);
    chk("sw acc0 mask", 32'(cap_wm[0]), 32'hC);
    chk("sw acc0 data", cap_wd[0], 32'h33440000);
    chk("sw acc1 addr", cap_ad[1], 32'd4);
    chk("sw acc1 mask", 32'(cap_wm[1]), 32'h3);
    chk("sw acc1 data", cap_wd[1], 32'h00001122);

    preload(3, 32'hDDCCBBAA);
    preload(4, 32'h44332211);
    do_req(1'b0, SZ_HU, 32'h0F, 32'h0, lat, rd, er);
    chk("lhu rdata", rd, 32'h000011DD);
    chk("lhu latency", 32'(lat), 32'd4);

    do_req(1'b0, SZ_W, 32'(4*D - 2), 32'h0, lat, rd, er);
    chk("lw oob err", 32'(er), 32'd1);
    chk("lw oob rdata", rd, 32'd0);
    chk("lw oob latency", 32'(lat), 32'd1);
    chk("lw oob strobes", 32'(cap_n), 32'd0);

    do_req(1'b0, 3'b011, 32'h8, 32'h0, lat, rd, er);
    chk("size011 err", 32'(er), 32'd1);

    // Held request: exactly one accept per pass through IDLE.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h0;
    rdy_cnt = 0; rsp_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready) rdy_cnt++;
      if (resp_valid) rsp_cnt++;
    end
    req_valid = 1'b0;
    chk("held ready cycles", 32'(rdy_cnt), 32'd2);
    chk("held responses", 32'(rsp_cnt), 32'd2);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] ad;
      if ($urandom_range(0, 9) == 0) ad = $urandom();
      else ad = $urandom_range(0, 4*D + 3);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom(), lat, rd, er);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset during the second half of a split store.
    preload(8, 32'h0);
    preload(9, 32'h5A5A5A5A);
    saved9 = ram[9];
    for (int k = 0; k < 4; k++) saved_sh[k] = sh[36 + k];
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h22; req_wdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort in acc1", mem_addr, 32'd9);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) sh[36 + k] = saved_sh[k];
    rsp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) rsp_cnt++;
    end
    chk("abort no resp", 32'(rsp_cnt), 32'd0);
    chk("abort acc1 untouched", ram[9], saved9);
    chk("abort acc0 written", ram[8], 32'hBABE0000);
    chk("abort ready", 32'(req_ready), 32'd1);

    do_req(1'b0, SZ_W, 32'h20, 32'h0, lat, rd, er);
    chk("post-abort lw", rd, 32'hBABE0000);

    @(negedge clk);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
